// File: rtl/store_pkg.sv
// Shared types and default widths for the store write engine.
package store_pkg;

    localparam int unsigned DefAddrW = 16;
    localparam int unsigned DefDataW = 32;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWrite,
        StWaitAck,
        StDone,
        StRelease
    } store_state_e;

endpackage

// File: rtl/store_ack_timer.sv
// Counts cycles spent waiting for a write ack; flags expiry at ACK_TIMEOUT-1.
module store_ack_timer #(
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

    logic [CntW-1:0] cnt_q;

    assign expired = (cnt_q == CntW'(ACK_TIMEOUT - 1));

    // Saturates at expiry so the count can never wrap.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/store_write_engine.sv
// Performs one bus write per store request: arbitrate, write, wait for ack with
// bounded timeout/retry, then pulse storeEnd back to the store control FSM.
module store_write_engine
    import store_pkg::*;
#(
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned ACK_TIMEOUT = 8,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memWrite,
    input  logic              swEnable,
    input  logic [ADDR_W-1:0] store_addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic              mem_gnt,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              storeEnd,
    output logic              store_err,
    output logic              busy
);

    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    store_state_e      state_q, state_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic              err_q, err_d;
    logic              capture;
    logic              expired;

    store_ack_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_ack_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q != StWaitAck),
        .enable (state_q == StWaitAck),
        .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        err_d   = err_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (memWrite && swEnable) begin
                    state_d = StReq;
                    retry_d = '0;
                    err_d   = 1'b0;
                    capture = 1'b1;
                end
            end
            StReq: begin
                if (mem_gnt) state_d = StWrite;
            end
            StWrite: begin
                state_d = mem_ack ? StDone : StWaitAck;
            end
            StWaitAck: begin
                // Ack wins over a timeout landing in the same cycle.
                if (mem_ack) begin
                    state_d = StDone;
                end else if (expired) begin
                    if (retry_q < RetryW'(MAX_RETRY)) begin
                        retry_d = retry_q + RetryW'(1);
                        state_d = StWrite;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StRelease;
            end
            StRelease: begin
                if (!memWrite) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            retry_q   <= '0;
            err_q     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            storeEnd  <= 1'b0;
            store_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            retry_q   <= retry_d;
            err_q     <= err_d;
            if (capture) begin
                mem_addr  <= store_addr;
                mem_wdata <= store_data;
            end
            mem_req   <= (state_d == StReq) || (state_d == StWrite) || (state_d == StWaitAck);
            mem_we    <= (state_d == StWrite);
            storeEnd  <= (state_d == StDone);
            store_err <= (state_d == StDone) && err_d;
            busy      <= (state_d != StIdle);
        end
    end

endmodule

// File: tb/tb_store_write_engine.sv
// Self-checking bench: per-store timeline model derived from grant delay and ack schedule.
module tb_store_write_engine;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 32;
    localparam int ACK_TIMEOUT = 8;
    localparam int MAX_RETRY   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              memWrite, swEnable;
    logic [ADDR_W-1:0] store_addr;
    logic [DATA_W-1:0] store_data;
    logic              mem_gnt, mem_ack;
    logic              mem_req, mem_we, storeEnd, store_err, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    int errors = 0;
    int checks = 0;

    store_write_engine #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memWrite  (memWrite),
        .swEnable  (swEnable),
        .store_addr(store_addr),
        .store_data(store_data),
        .mem_gnt   (mem_gnt),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .storeEnd  (storeEnd),
        .store_err (store_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] obs();
        return {mem_req, mem_we, storeEnd, store_err, busy};
    endfunction

    // One store transaction. ackN is the ack delay (cycles after that attempt's
    // write cycle, 0..ACK_TIMEOUT) or -1 for no ack. Entered just after a posedge, DUT idle.
    task automatic run_store(input string name, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data, input int gdly,
                             input int ack0, input int ack1, input int ack2, input int hold);
        int ackd[3];
        int wr[3];
        int nwr, done, endc, last, w, ack_cyc;
        bit err, fin, exp_we, exp_ack;
        logic [4:0] exp;
        ackd[0] = ack0; ackd[1] = ack1; ackd[2] = ack2;
        nwr = 0; done = 0; err = 0; fin = 0; ack_cyc = -1;
        w = 2 + gdly;
        for (int i = 0; i <= MAX_RETRY; i++) begin
            if (!fin) begin
                wr[nwr] = w; nwr++;
                if (ackd[i] >= 0) begin
                    ack_cyc = w + ackd[i];
                    done = ack_cyc + 1;
                    fin = 1;
                end else if (i == MAX_RETRY) begin
                    done = w + ACK_TIMEOUT + 1;
                    err = 1;
                    fin = 1;
                end else begin
                    w = w + ACK_TIMEOUT + 1;
                end
            end
        end
        endc = done + 1 + hold;
        last = endc + 3;
        for (int c = 0; c <= last; c++) begin
            exp_we = 0;
            for (int i = 0; i < nwr; i++) if (wr[i] == c) exp_we = 1;
            memWrite = (c < endc);
            swEnable = 1'b1;
            store_addr = (c == 0) ? addr : ((c <= 2 + gdly) ? 16'h1234 : ADDR_W'($urandom));
            store_data = (c == 0) ? data : $urandom;
            if (c == 0 || c >= done) mem_gnt = 1'($urandom);
            else mem_gnt = (c >= 1 + gdly);
            exp_ack = (c == ack_cyc);
            if (c < wr[0] || c >= done) mem_ack = 1'($urandom);
            else mem_ack = exp_ack;
            exp = {(c >= 1 && c < done), exp_we, (c == done), (c == done) && err,
                   (c >= 1 && c <= endc)};
            @(negedge clk);
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d outputs{req,we,end,err,busy}: got %b expected %b",
                         name, c, obs(), exp);
            end
            if (exp_we) begin
                checks++;
                if (mem_addr !== addr || mem_wdata !== data) begin
                    errors++;
                    $display("FAIL %s cycle %0d write addr/data: got %h/%h expected %h/%h",
                             name, c, mem_addr, mem_wdata, addr, data);
                end
            end
            @(posedge clk); #1;
        end
        memWrite = 1'b0; mem_gnt = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; memWrite = 1'b1; swEnable = 1'b1; mem_gnt = 1'b1; mem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (obs() !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset outputs: got %b %h %h expected 00000 0000 00000000",
                     obs(), mem_addr, mem_wdata);
        end
        memWrite = 1'b0; mem_gnt = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_no_start();
        for (int c = 0; c < 8; c++) begin
            memWrite = (c < 4); swEnable = (c >= 4);
            mem_gnt = 1'($urandom); mem_ack = 1'($urandom);
            store_addr = ADDR_W'($urandom); store_data = $urandom;
            @(negedge clk);
            checks++;
            if (obs() !== 5'b0) begin
                errors++;
                $display("FAIL no_start cycle %0d: got %b expected 00000", c, obs());
            end
            @(posedge clk); #1;
        end
        memWrite = 1'b0; mem_gnt = 1'b0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop();
        memWrite = 1'b1; swEnable = 1'b1; mem_gnt = 1'b1; mem_ack = 1'b0;
        store_addr = 16'hBEEF; store_data = 32'hCAFEF00D;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1; memWrite = 1'b0; mem_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== 5'b10001) begin
            errors++;
            $display("FAIL reset_midop wait_ack: got %b expected 10001", obs());
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (obs() !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
                errors++;
                $display("FAIL reset_midop after cycle %0d: got %b %h %h expected 00000 0 0",
                         c, obs(), mem_addr, mem_wdata);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; memWrite = 1'b0; swEnable = 1'b0; mem_gnt = 1'b0; mem_ack = 1'b0;
        store_addr = '0; store_data = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        run_store("immediate", 16'h0040, 32'hDEADBEEF, 0, 0, -1, -1, 0);
        run_store("delayed_grant", 16'h0100, 32'h01234567, 5, 0, -1, -1, 0);
        run_store("ack_latency", 16'h0200, 32'h89ABCDEF, 0, 3, -1, -1, 0);
        run_store("retries", 16'h0300, 32'h55AA55AA, 1, -1, -1, -1, 0);
        run_store("ack_at_timeout", 16'h0400, 32'h0F0F0F0F, 0, -1, ACK_TIMEOUT, -1, 1);
        run_store("release_hold", 16'h0500, 32'h11112222, 2, 1, -1, -1, 4);
        run_store("back_to_back", 16'hFFFF, 32'hFFFFFFFF, 0, 0, -1, -1, 0);
        test_no_start();
        test_reset_midop();
        run_store("after_reset", 16'h0600, 32'h33334444, 0, 2, -1, -1, 0);
        for (int n = 0; n < 20; n++) begin
            run_store("random", ADDR_W'($urandom), $urandom, int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 9)) - 1, int'($urandom_range(0, 9)) - 1,
                      int'($urandom_range(0, 9)) - 1, int'($urandom_range(0, 3)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
